// File: rtl/text_pkg.sv
// text_pkg: shared constants, state encoding and row/address mapping for the
// 80x30 text console (text_buffer and text_ram).
package text_pkg;

  localparam int unsigned COLS  = 80;
  localparam int unsigned ROWS  = 30;
  localparam int unsigned CELLS = COLS * ROWS;

  localparam logic [6:0]  LAST_COL  = 7'(COLS - 1);
  localparam logic [4:0]  LAST_ROW  = 5'(ROWS - 1);
  localparam logic [11:0] LAST_CELL = 12'(CELLS - 1);

  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_BS    = 8'h08;

  typedef enum logic [1:0] {
    StInit,
    StIdle,
    StClearRow
  } state_e;

  // Display row -> physical row through the circular top_row offset.
  // row + top never exceeds 58, so one conditional subtract is enough.
  function automatic logic [4:0] map_row(input logic [4:0] row, input logic [4:0] top);
    logic [5:0] sum;
    logic [5:0] wrapped;
    sum     = {1'b0, row} + {1'b0, top};
    wrapped = (sum >= 6'd30) ? (sum - 6'd30) : sum;
    return 5'(wrapped);
  endfunction

  // phys_row*80 + x, as shifts.
  function automatic logic [11:0] cell_addr(input logic [4:0] phys, input logic [6:0] x);
    return ({7'b0, phys} << 6) + ({7'b0, phys} << 4) + {5'b0, x};
  endfunction

endpackage

// File: rtl/text_ram.sv
// text_ram: 2400 x 7 character store. One synchronous write port, one
// asynchronous read port (distributed RAM). A same-cycle write and read of one
// cell returns the old contents.
// Ports: clk, we/waddr/wdata (write), raddr/rdata (combinational read).
module text_ram
  import text_pkg::*;
#(
  parameter int unsigned Depth = CELLS
) (
  input  logic        clk,
  input  logic        we,
  input  logic [11:0] waddr,
  input  logic [6:0]  wdata,
  input  logic [11:0] raddr,
  output logic [6:0]  rdata
);

  logic [6:0] mem [Depth];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/text_buffer.sv
// text_buffer: character memory and terminal-style write engine for an 80x30
// console. Accepts bytes on a valid/ready handshake, handles printable chars,
// LF, CR and BS, wraps lines, and clears rows. Serves the display controller
// with a combinational read at (read_x, read_y).
// Optional feature macro: TEXT_BUFFER_SCROLL_EN -- newline on the last row
// scrolls via a circular top_row; otherwise the cursor wraps to row 0 and
// every newline clears its destination row.
// Ports: clk, reset (async, active-low), in_data/in_valid/in_ready (byte
// stream), read_x/read_y/char_at_pos (display read), cursor_x/cursor_y, busy.
module text_buffer
  import text_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [6:0] read_x,
  input  logic [4:0] read_y,
  output logic [6:0] char_at_pos,
  output logic [6:0] cursor_x,
  output logic [4:0] cursor_y,
  output logic       busy
);

  state_e      state;
  logic [11:0] init_cnt;
  logic [6:0]  clr_cnt;
  logic [4:0]  clr_row;
  logic [6:0]  cx;
  logic [4:0]  cy;
  logic [4:0]  top_row;

  logic        accept;
  logic        is_print;
  logic        newline;
  logic [4:0]  cur_phys;

  logic        we;
  logic [11:0] waddr;
  logic [6:0]  wdata;
  logic        rd_ok;
  logic [11:0] raddr;
  logic [6:0]  rdata;

  assign in_ready = (state == StIdle);
  assign busy     = ~in_ready;
  assign cursor_x = cx;
  assign cursor_y = cy;

  assign accept   = in_valid && in_ready;
  assign is_print = !in_data[7] && (in_data[6:0] >= 7'h20) && (in_data[6:0] != 7'h7F);
  assign newline  = accept && ((is_print && (cx == LAST_COL)) || (in_data == CH_LF));
  assign cur_phys = map_row(cy, top_row);

`ifndef TEXT_BUFFER_SCROLL_EN
  assign top_row = 5'd0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= StInit;
      init_cnt <= '0;
      clr_cnt  <= '0;
      clr_row  <= '0;
      cx       <= '0;
      cy       <= '0;
`ifdef TEXT_BUFFER_SCROLL_EN
      top_row  <= '0;
`endif
    end else begin
      case (state)
        StInit: begin
          init_cnt <= init_cnt + 12'd1;
          if (init_cnt == LAST_CELL) begin
            init_cnt <= '0;
            state    <= StIdle;
          end
        end
        StClearRow: begin
          clr_cnt <= clr_cnt + 7'd1;
          if (clr_cnt == LAST_COL) begin
            clr_cnt <= '0;
            state   <= StIdle;
          end
        end
        StIdle: begin
          if (accept) begin
            if (is_print) begin
              cx <= (cx == LAST_COL) ? 7'd0 : cx + 7'd1;
            end else if ((in_data == CH_LF) || (in_data == CH_CR)) begin
              cx <= '0;
            end else if ((in_data == CH_BS) && (cx != 7'd0)) begin
              cx <= cx - 7'd1;
            end
            if (newline) begin
`ifdef TEXT_BUFFER_SCROLL_EN
              if (cy != LAST_ROW) begin
                cy <= cy + 5'd1;
              end else begin
                // The old top row becomes the new bottom row; blank it.
                top_row <= (top_row == LAST_ROW) ? 5'd0 : top_row + 5'd1;
                clr_row <= top_row;
                clr_cnt <= '0;
                state   <= StClearRow;
              end
`else
              cy      <= (cy == LAST_ROW) ? 5'd0 : cy + 5'd1;
              clr_row <= (cy == LAST_ROW) ? 5'd0 : cy + 5'd1;
              clr_cnt <= '0;
              state   <= StClearRow;
`endif
            end
          end
        end
        default: state <= StInit;
      endcase
    end
  end

  // RAM write port: init sweep, row clear, or the byte being accepted.
  always_comb begin
    we    = 1'b0;
    waddr = '0;
    wdata = CH_SPACE[6:0];
    case (state)
      StInit: begin
        we    = 1'b1;
        waddr = init_cnt;
      end
      StClearRow: begin
        we    = 1'b1;
        waddr = cell_addr(clr_row, clr_cnt);
      end
      StIdle: begin
        if (accept && is_print) begin
          we    = 1'b1;
          waddr = cell_addr(cur_phys, cx);
          wdata = in_data[6:0];
        end else if (accept && (in_data == CH_BS) && (cx != 7'd0)) begin
          we    = 1'b1;
          waddr = cell_addr(cur_phys, cx - 7'd1);
        end
      end
      default: ;
    endcase
  end

  // Out-of-range coordinates read as a space; keep the RAM address in range.
  assign rd_ok       = (read_x <= LAST_COL) && (read_y <= LAST_ROW);
  assign raddr       = rd_ok ? cell_addr(map_row(read_y, top_row), read_x) : 12'd0;
  assign char_at_pos = rd_ok ? rdata : CH_SPACE[6:0];

  text_ram u_ram (
    .clk  (clk),
    .we   (we),
    .waddr(waddr),
    .wdata(wdata),
    .raddr(raddr),
    .rdata(rdata)
  );

endmodule
